// File: rtl/button_event_gen.sv
// button_event_gen: turns a debounced button level into single-cycle
// press / release / long-press / auto-repeat strobes plus a held level.
// Optional feature macro: BTN_AUTO_REPEAT_EN enables o_repeat pulses while
// long-held; without it o_repeat stays 0 and the counter idles in LONG_HELD.
// Every output comes from a flop, one cycle after the edge that samples i_in.
module button_event_gen #(
    parameter int unsigned long_press_cycles = 50_000_000,
    parameter int unsigned repeat_cycles     = 10_000_000,
    parameter int unsigned cnt_w             = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_repeat,
    output logic o_held
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    // Counter value at the edge where the long-press threshold is reached.
    localparam logic [cnt_w-1:0] LONG_LAST = cnt_w'(long_press_cycles - 1);
`ifdef BTN_AUTO_REPEAT_EN
    // Counter value at the edge where one repeat period has elapsed.
    localparam logic [cnt_w-1:0] REP_LAST  = cnt_w'(repeat_cycles - 1);
`endif

    state_t           state_q, state_d;
    logic [cnt_w-1:0] cnt_q, cnt_d;
    logic             prev_q, prev_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;
    logic             held_q, held_d;

    // Next-state, hold counter and next-cycle pulse decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        prev_d  = i_in;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rpt_d   = 1'b0;
        held_d  = 1'b0;

        case (state_q)
            IDLE: begin
                // prev_q clears on reset, so a button held through reset
                // still registers as a fresh press once reset drops.
                if (i_in && !prev_q) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                // Release wins over the long-press threshold on the same edge.
                if (!i_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    cnt_d   = '0;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_w'(1);
                end
            end
            LONG_HELD: begin
                if (!i_in) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (cnt_q == REP_LAST) begin
                        cnt_d = '0;
                        rpt_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + cnt_w'(1);
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d != IDLE);
    end

    // State, counter, input history and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
            held_q  <= held_d;
        end
    end

    assign o_press   = press_q;
    assign o_release = rel_q;
    assign o_long    = long_q;
    assign o_repeat  = rpt_q;
    assign o_held    = held_q;

endmodule

// File: tb/tb_button_event_gen.sv
// Testbench for button_event_gen with long_press_cycles = 10, repeat_cycles = 4.
// Expected outputs come from a timing model of a single press of a given
// length; o_repeat expectations follow BTN_AUTO_REPEAT_EN.
// Output vector bit order: {press, release, long, repeat, held}.
module tb_button_event_gen;

    localparam int L = 10;
    localparam int R = 4;

    logic i_clk;
    logic i_rst;
    logic i_in;
    logic o_press, o_release, o_long, o_repeat, o_held;

    logic [4:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    button_event_gen #(
        .long_press_cycles(L),
        .repeat_cycles    (R),
        .cnt_w            (8)
    ) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_in     (i_in),
        .o_press  (o_press),
        .o_release(o_release),
        .o_long   (o_long),
        .o_repeat (o_repeat),
        .o_held   (o_held)
    );

    // Clock and reset.
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [4:0] outs();
        return {o_press, o_release, o_long, o_repeat, o_held};
    endfunction

    // Expected output in cycle k (k = 0 is the o_press cycle) for a press
    // whose i_in stays high for 'hold' sampling edges.
    function automatic logic [4:0] exp_hold(input int k, input int hold);
        logic [4:0] v;
        v = 5'b00000;
        if (k == hold) begin
            v = 5'b01000;
        end else if (k < hold) begin
            v[0] = 1'b1;
            if (k == 0) v[4] = 1'b1;
            if (k == L) v[2] = 1'b1;
`ifdef BTN_AUTO_REPEAT_EN
            if (k > L && ((k - L) % R) == 0) v[1] = 1'b1;
`endif
        end
        return v;
    endfunction

    // Driver: apply inputs for the next edge and queue the response expected
    // in the cycle that edge opens; returns at the following negedge.
    task automatic step(input logic rst, input logic in, input logic [4:0] e);
        i_rst = rst;
        i_in  = in;
        exp_q.push_back(e);
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        logic [4:0] got, e;
        for (int t = 0; t < 3; t++) begin
            step(1'b1, 1'b1, 5'b00000);
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_hold t=%0d got=%b exp=%b", t, got, e);
            end
        end
        // Button still held as reset drops: press in the first cycle out.
        for (int t = 0; t < 6; t++) begin
            step(1'b0, (t < 3), exp_hold(t, 3));
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_release t=%0d got=%b exp=%b", t, got, e);
            end
        end
    endtask

    task automatic test_short_press();
        logic [4:0] got, e;
        for (int t = 0; t < 8; t++) begin
            step(1'b0, (t < 5), exp_hold(t, 5));
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL short_press t=%0d got=%b exp=%b", t, got, e);
            end
        end
    endtask

    task automatic test_long_press();
        logic [4:0] got, e;
        for (int t = 0; t < 23; t++) begin
            step(1'b0, (t < 20), exp_hold(t, 20));
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL long_press t=%0d got=%b exp=%b", t, got, e);
            end
        end
    endtask

    task automatic test_collision();
        logic [4:0] got, e;
        for (int t = 0; t < 13; t++) begin
            step(1'b0, (t < L), exp_hold(t, L));
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL collision t=%0d got=%b exp=%b", t, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_hold();
        logic [4:0] got, e;
        logic       rst;
        for (int t = 0; t < 30; t++) begin
            rst = (t == 13);
            if (t < 13)       e = exp_hold(t, 100);
            else if (t == 13) e = 5'b00000;
            else              e = exp_hold(t - 14, 12);
            step(rst, (t < 26), e);
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL reset_mid_hold t=%0d got=%b exp=%b", t, got, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got, e;
        for (int t = 0; t < 6; t++) begin
            e = (t < 2) ? exp_hold(t, 1) : exp_hold(t - 2, 1);
            step(1'b0, (t == 0 || t == 2), e);
            got = outs(); e = exp_q.pop_front(); checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL back_to_back t=%0d got=%b exp=%b", t, got, e);
            end
        end
    endtask

    task automatic test_random_holds();
        logic [4:0] got, e;
        int hold, gap;
        for (int n = 0; n < 6; n++) begin
            hold = $urandom_range(1, 24);
            gap  = $urandom_range(1, 3);
            for (int t = 0; t < hold + gap; t++) begin
                step(1'b0, (t < hold), exp_hold(t, hold));
                got = outs(); e = exp_q.pop_front(); checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL random_hold n=%0d hold=%0d t=%0d got=%b exp=%b",
                             n, hold, t, got, e);
                end
            end
        end
    endtask

    initial begin
        i_rst = 1'b1;
        i_in  = 1'b0;
        @(negedge i_clk);
        test_reset();
        test_short_press();
        test_long_press();
        test_collision();
        test_reset_mid_hold();
        test_back_to_back();
        test_random_holds();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
